// File: rtl/qadd_arbiter.sv
// Round-robin arbiter in front of one shared sign-magnitude Q-format adder.
// One transaction in flight: IDLE grants and latches, CALC adds, OUT holds the result until consumed.
module qadd_arbiter #(
  parameter int Q       = 15,
  parameter int N       = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [NUM_REQ-1:0]         s_valid,
  output logic [NUM_REQ-1:0]         s_ready,
  input  logic [NUM_REQ*N-1:0]       s_a,
  input  logic [NUM_REQ*N-1:0]       s_b,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [N-1:0]               m_result,
  output logic [$clog2(NUM_REQ)-1:0] m_tag,
  output logic                       m_overflow,
  output logic                       busy
);

  localparam int TAG_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || Q < 0 || Q > N - 1) begin : g_param_check
    $error("qadd_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

  state_t             state, state_next;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   grant;
  logic               found;
  logic [N-1:0]       a_p0, b_p0;

  // Returns {overflow, sign, magnitude}; a zero magnitude always carries a positive sign.
  function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-2:0] ma, mb;
    logic [N-1:0] mag;
    logic         sign;
    ma = a[N-2:0];
    mb = b[N-2:0];
    if (a[N-1] == b[N-1]) begin
      mag  = {1'b0, ma} + {1'b0, mb};
      sign = a[N-1];
    end else if (ma >= mb) begin
      mag  = {1'b0, ma - mb};
      sign = a[N-1];
    end else begin
      mag  = {1'b0, mb - ma};
      sign = b[N-1];
    end
    if (mag[N-2:0] == '0) sign = 1'b0;
    return {mag[N-1], sign, mag[N-2:0]};
  endfunction

  // First valid requester at or above rr_ptr, wrapping around.
  always_comb begin
    int               idx;
    logic [TAG_W-1:0] idx_t;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    idx_t = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = TAG_W'(idx);
      if (!found && s_valid[idx_t]) begin
        grant = idx_t;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    s_ready    = '0;
    unique case (state)
      IDLE: begin
        if (found && aresetn) begin
          s_ready[grant] = 1'b1;
          state_next     = CALC;
        end
      end
      CALC:    state_next = OUT;
      OUT:     if (m_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_next;
  end

  assign busy = (state != IDLE);

  // Stage p0: operands captured on the accept edge.
  always_ff @(posedge aclk) begin
    if (state == IDLE && found) begin
      a_p0 <= s_a[int'(grant)*N +: N];
      b_p0 <= s_b[int'(grant)*N +: N];
    end
  end

  // Stage p1: sum registered onto the result port and held until consumed.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr     <= '0;
      m_valid    <= 1'b0;
      m_result   <= '0;
      m_tag      <= '0;
      m_overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            m_tag  <= grant;
            rr_ptr <= (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          end
        end
        CALC: begin
          m_valid                <= 1'b1;
          {m_overflow, m_result} <= sm_add(a_p0, b_p0);
        end
        OUT:     if (m_ready) m_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qadd_arbiter.sv
// Randomized bench for qadd_arbiter against a signed-integer adder model and a round-robin pick model.
module tb_qadd_arbiter;
  localparam int N  = 32;
  localparam int Q  = 15;
  localparam int NR = 4;
  localparam int TW = 2;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NR-1:0]     s_valid;
  logic [NR-1:0]     s_ready;
  logic [NR*N-1:0]   s_a, s_b;
  logic              m_valid;
  logic              m_ready;
  logic [N-1:0]      m_result;
  logic [TW-1:0]     m_tag;
  logic              m_overflow;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  int rr_model    = 0;

  qadd_arbiter #(.Q(Q), .N(N), .NUM_REQ(NR)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .m_valid(m_valid), .m_ready(m_ready),
    .m_result(m_result), .m_tag(m_tag), .m_overflow(m_overflow), .busy(busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: sign-magnitude operands interpreted as signed integers.
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b);
    longint ma, mb, s, lim;
    logic   neg, ovf;
    lim = longint'(1) << (N - 1);
    ma  = longint'(a[N-2:0]);
    mb  = longint'(b[N-2:0]);
    if (a[N-1] == b[N-1]) begin
      s   = ma + mb;
      ovf = (s >= lim);
      s   = s % lim;
      neg = a[N-1];
    end else begin
      s   = (a[N-1] ? -ma : ma) + (b[N-1] ? -mb : mb);
      ovf = 1'b0;
      neg = (s < 0);
      if (s < 0) s = -s;
    end
    if (s == 0) neg = 1'b0;
    return {ovf, neg, s[N-2:0]};
  endfunction

  function automatic int ref_grant(input logic [NR-1:0] mask, input int ptr);
    for (int k = 0; k < NR; k++)
      if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: v[N-2:0] = '0;
      1: v[N-2:0] = '1;
      2: v[N-2:0] = (N-1)'($urandom_range(0, 3));
      default: ;
    endcase
    return v;
  endfunction

  // Presents one request set, takes the accept edge, then waits (bounded) for m_valid.
  task automatic send(input logic [NR-1:0] vm, input logic [NR*N-1:0] av, input logic [NR*N-1:0] bv,
                      output logic [NR-1:0] rdy, output int lat);
    s_valid = vm;
    s_a     = av;
    s_b     = bv;
    #1;
    rdy = s_ready;
    @(posedge aclk); #1;
    s_valid = '0;
    lat = 0;
    while (!m_valid && lat < 10) begin
      @(posedge aclk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    m_ready = 1'b1;
    @(posedge aclk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_valid = '1;
    s_a     = {$urandom, $urandom, $urandom, $urandom};
    s_b     = {$urandom, $urandom, $urandom, $urandom};
    m_ready = 1'b1;
    @(posedge aclk); #1;
    vectors++;
    if (s_ready !== '0) begin miscompares++; $display("FAIL reset_s_ready: got %b expected 0000", s_ready); end
    @(posedge aclk); #1;
    vectors++;
    if ({m_valid, m_overflow, busy} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags: got valid/ovf/busy=%b expected 000", {m_valid, m_overflow, busy});
    end
    vectors++;
    if (m_result !== '0 || m_tag !== '0) begin
      miscompares++; $display("FAIL reset_data: got result=%h tag=%0d expected 0/0", m_result, m_tag);
    end
    s_valid = '0;
    m_ready = 1'b0;
    aresetn = 1'b1;
    rr_model = 0;
  endtask

  task automatic test_directed();
    int           req [6] = '{2, 1, 3, 0, 2, 1};
    logic [N-1:0] ta  [6] = '{32'h0000_8000, 32'h8000_4000, 32'h8000_8000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [N-1:0] tb  [6] = '{32'h8000_4000, 32'h0000_4000, 32'h8000_4000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0005};
    logic [N-1:0] tr  [6] = '{32'h0000_4000, 32'h0000_0000, 32'h8000_C000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0005};
    logic         tov [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [NR-1:0]   rdy, vm;
    logic [NR*N-1:0] av, bv;
    int              lat;
    for (int i = 0; i < 6; i++) begin
      vm = '0; vm[req[i]] = 1'b1;
      av = '0; av[req[i]*N +: N] = ta[i];
      bv = '0; bv[req[i]*N +: N] = tb[i];
      send(vm, av, bv, rdy, lat);
      vectors++;
      if (rdy !== vm) begin miscompares++; $display("FAIL dir_ready[%0d]: got %b expected %b", i, rdy, vm); end
      vectors++;
      if (lat !== 1) begin miscompares++; $display("FAIL dir_latency[%0d]: got %0d extra edges expected 1", i, lat); end
      vectors++;
      if (m_result !== tr[i] || m_overflow !== tov[i] || m_tag !== TW'(req[i])) begin
        miscompares++;
        $display("FAIL dir_result[%0d]: got %h ovf=%b tag=%0d expected %h ovf=%b tag=%0d",
                 i, m_result, m_overflow, m_tag, tr[i], tov[i], req[i]);
      end
      rr_model = (req[i] + 1) % NR;
      consume();
      vectors++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL dir_release[%0d]: got valid=%b busy=%b expected 0 0", i, m_valid, busy);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0]   rdy;
    logic [NR*N-1:0] av, bv;
    logic [N:0]      exp;
    int              lat, g;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    rr_model = 0;
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < NR; r++) begin av[r*N +: N] = rand_op(); bv[r*N +: N] = rand_op(); end
      g   = ref_grant('1, rr_model);
      exp = ref_add(av[g*N +: N], bv[g*N +: N]);
      send('1, av, bv, rdy, lat);
      vectors++;
      if ($countones(rdy) != 1 || rdy !== NR'(1 << g)) begin
        miscompares++; $display("FAIL rr_grant[%0d]: got s_ready=%b expected requester %0d", k, rdy, g);
      end
      vectors++;
      if (m_tag !== TW'(g) || {m_overflow, m_result} !== exp) begin
        miscompares++;
        $display("FAIL rr_result[%0d]: got tag=%0d %b/%h expected tag=%0d %b/%h",
                 k, m_tag, m_overflow, m_result, g, exp[N], exp[N-1:0]);
      end
      rr_model = (g + 1) % NR;
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0]   rdy, vm;
    logic [NR*N-1:0] av, bv;
    logic [N:0]      exp;
    int              lat, g;
    vm = 4'b0110;
    for (int r = 0; r < NR; r++) begin av[r*N +: N] = rand_op(); bv[r*N +: N] = rand_op(); end
    g   = ref_grant(vm, rr_model);
    exp = ref_add(av[g*N +: N], bv[g*N +: N]);
    send(vm, av, bv, rdy, lat);
    rr_model = (g + 1) % NR;
    vectors++;
    if (m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid: got %b expected 1", m_valid); end
    for (int c = 0; c < 5; c++) begin
      s_valid = '1;
      @(posedge aclk); #1;
      vectors++;
      if (m_valid !== 1'b1 || busy !== 1'b1 || s_ready !== '0 || m_tag !== TW'(g) || {m_overflow, m_result} !== exp) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b busy=%b rdy=%b tag=%0d res=%h expected 1 1 0000 %0d %h",
                 c, m_valid, busy, s_ready, m_tag, m_result, g, exp[N-1:0]);
      end
    end
    s_valid = '0;
    consume();
    vectors++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", m_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [NR-1:0]   rdy;
    logic [NR*N-1:0] av, bv;
    int              lat, g;
    av = '0; bv = '0;
    av[1*N +: N] = 32'h0000_1234; bv[1*N +: N] = 32'h0000_0001;
    send(4'b0010, av, bv, rdy, lat);
    consume();
    av[3*N +: N] = 32'h0000_0100; bv[3*N +: N] = 32'h0000_0200;
    s_valid = 4'b1000; s_a = av; s_b = bv;
    @(posedge aclk); #1;
    s_valid = '0;
    aresetn = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    vectors++;
    if ({m_valid, m_overflow, busy} !== 3'b000 || m_result !== '0 || m_tag !== '0) begin
      miscompares++;
      $display("FAIL midreset_clear: got valid=%b ovf=%b busy=%b res=%h tag=%0d expected all 0",
               m_valid, m_overflow, busy, m_result, m_tag);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk); #1;
      vectors++;
      if (m_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_no_valid[%0d]: got %b expected 0", c, m_valid); end
    end
    rr_model = 0;
    g = ref_grant(4'b1010, rr_model);
    send(4'b1010, av, bv, rdy, lat);
    vectors++;
    if (rdy !== NR'(1 << g) || m_tag !== TW'(g) || m_result !== 32'h0000_1235) begin
      miscompares++;
      $display("FAIL midreset_regrant: got rdy=%b tag=%0d res=%h expected requester %0d res 00001235", rdy, m_tag, m_result, g);
    end
    rr_model = (g + 1) % NR;
    consume();
  endtask

  task automatic test_random();
    logic [NR-1:0]   rdy, vm;
    logic [NR*N-1:0] av, bv;
    logic [N:0]      exp;
    int              lat, g;
    for (int k = 0; k < 40; k++) begin
      vm = NR'($urandom_range(1, (1 << NR) - 1));
      for (int r = 0; r < NR; r++) begin
        av[r*N +: N] = rand_op();
        bv[r*N +: N] = rand_op();
        if ($urandom_range(0, 4) == 0) bv[r*N +: N] = {~av[r*N + N - 1], av[r*N +: N-1]};
      end
      g   = ref_grant(vm, rr_model);
      exp = ref_add(av[g*N +: N], bv[g*N +: N]);
      send(vm, av, bv, rdy, lat);
      vectors++;
      if (rdy !== NR'(1 << g)) begin miscompares++; $display("FAIL rand_grant[%0d]: got %b expected requester %0d", k, rdy, g); end
      vectors++;
      if (lat !== 1) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d expected 1", k, lat); end
      vectors++;
      if (m_tag !== TW'(g) || {m_overflow, m_result} !== exp) begin
        miscompares++;
        $display("FAIL rand_result[%0d]: a=%h b=%h got tag=%0d %b/%h expected tag=%0d %b/%h", k,
                 av[g*N +: N], bv[g*N +: N], m_tag, m_overflow, m_result, g, exp[N], exp[N-1:0]);
      end
      rr_model = (g + 1) % NR;
      repeat ($urandom_range(0, 2)) @(posedge aclk);
      #1;
      consume();
    end
  endtask

  initial begin
    aresetn = 1'b0;
    s_valid = '0;
    s_a     = '0;
    s_b     = '0;
    m_ready = 1'b0;
    test_reset();
    test_directed();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
